cmp_arbiter: RTL and testbench

- Shares the single ALU comparer between NUM_REQ requesters (decode, branch unit, loop counter, etc.).
- Round-robin arbitration; operands are latched, compared, and the relation code is returned with the requester id over a valid/ready result port.
- Sits in bb_core/alu between the requesting units and the comparer instance it owns.

---
 rtl/cmp_arbiter_pkg.sv | 17 +
 rtl/cmp_arbiter_comparer.sv | 37 +++
 rtl/cmp_arbiter.sv | 127 ++++++++++++
 tb/tb_cmp_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_arbiter_pkg.sv
// Shared constants and types for the comparer arbiter: operand width,
// relation codes and FSM state encoding.
package cmp_arbiter_pkg;

    localparam int unsigned CMP_DATA_WIDTH = 16;

    localparam logic [7:0] REL_LT = 8'h3C;
    localparam logic [7:0] REL_EQ = 8'h3D;
    localparam logic [7:0] REL_GT = 8'h3E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cmp_arbiter_comparer.sv
// Unsigned comparer with a registered relation output, loaded only when enabled
// so the result stays stable while the arbiter waits for the consumer.
module cmp_arbiter_comparer
    import cmp_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CMP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic [DATA_WIDTH-1:0] o_relation
);

    logic [DATA_WIDTH-1:0] w_rel;
    logic [DATA_WIDTH-1:0] r_rel;

    always_comb begin
        if (i_data0 < i_data1)
            w_rel = DATA_WIDTH'(REL_LT);
        else if (i_data0 == i_data1)
            w_rel = DATA_WIDTH'(REL_EQ);
        else
            w_rel = DATA_WIDTH'(REL_GT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_rel <= '0;
        else if (i_en)
            r_rel <= w_rel;
    end

    assign o_relation = r_rel;

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparer between NUM_REQ requesters;
// operands are latched on grant and the relation is returned with the requester id.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned DATA_WIDTH = CMP_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data0,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data1,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [DATA_WIDTH-1:0]         o_res_relation,
    output logic [ID_W-1:0]               o_res_id,
    output logic                          o_busy
);

    arb_state_t            r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_id;
    logic [DATA_WIDTH-1:0] r_op0;
    logic [DATA_WIDTH-1:0] r_op1;
    logic                  r_res_valid;
    logic                  r_busy;

    logic                  w_acc;
    logic                  w_found;
    logic [ID_W-1:0]       w_scan;
    logic [ID_W-1:0]       w_grant_id;
    logic [NUM_REQ-1:0]    w_grant;
    logic [DATA_WIDTH-1:0] w_op0;
    logic [DATA_WIDTH-1:0] w_op1;

    assign w_acc = rst_n && ((r_state == ST_IDLE) || (r_state == ST_RESP && i_res_ready));

    // Scan from the slot after the last winner, wrapping, and take the first valid one.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_grant_id = '0;
        w_scan     = '0;
        w_op0      = '0;
        w_op1      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_scan = ID_W'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (w_acc && !w_found && i_req_valid[w_scan]) begin
                w_found         = 1'b1;
                w_grant_id      = w_scan;
                w_grant[w_scan] = 1'b1;
                w_op0           = i_req_data0[32'(w_scan)*DATA_WIDTH +: DATA_WIDTH];
                w_op1           = i_req_data1[32'(w_scan)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_req_ready = w_grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_op0       <= '0;
            r_op1       <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_op0    <= w_op0;
                        r_op1    <= w_op1;
                        r_id     <= w_grant_id;
                        r_rr_ptr <= w_grant_id;
                        r_state  <= ST_CMP;
                        r_busy   <= 1'b1;
                    end
                end
                ST_CMP: begin
                    r_res_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_found) begin
                            r_op0    <= w_op0;
                            r_op1    <= w_op1;
                            r_id     <= w_grant_id;
                            r_rr_ptr <= w_grant_id;
                            r_state  <= ST_CMP;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    cmp_arbiter_comparer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_comparer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (r_state == ST_CMP),
        .i_data0   (r_op0),
        .i_data1   (r_op1),
        .o_relation(o_res_relation)
    );

    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_id;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scenario bench for cmp_arbiter: grants are recorded into a scoreboard as they
// happen and every delivered result is popped and compared.
module tb_cmp_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     i_req_valid;
    logic [NR-1:0]     o_req_ready;
    logic [NR*DW-1:0]  i_req_data0;
    logic [NR*DW-1:0]  i_req_data1;
    logic              o_res_valid;
    logic              i_res_ready;
    logic [DW-1:0]     o_res_relation;
    logic [IW-1:0]     o_res_id;
    logic              o_busy;

    int errors = 0;
    int checks = 0;
    logic [IW+DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    cmp_arbiter #(
        .NUM_REQ(NR),
        .ID_W(IW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_data0(i_req_data0),
        .i_req_data1(i_req_data1),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_relation(o_res_relation),
        .o_res_id(o_res_id),
        .o_busy(o_busy)
    );

    function automatic logic [DW-1:0] rel_model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a < b) return 16'h003C;
        if (a == b) return 16'h003D;
        return 16'h003E;
    endfunction

    // Scoreboard: pop on result handshake, push on request transfer; reset drops everything.
    always @(negedge clk) begin
        logic [IW+DW-1:0] exp_v;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (o_res_valid && i_res_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got id=%0d rel=%h, expected none", o_res_id, o_res_relation);
                end else begin
                    exp_v = sb_q.pop_front();
                    if ({o_res_id, o_res_relation} !== exp_v) begin
                        errors++;
                        $display("FAIL result: got id=%0d rel=%h, expected id=%0d rel=%h",
                                 o_res_id, o_res_relation, exp_v[IW+DW-1:DW], exp_v[DW-1:0]);
                    end
                end
            end
            for (int k = 0; k < NR; k++) begin
                if (o_req_ready[k] && i_req_valid[k])
                    sb_q.push_back({IW'(k), rel_model(i_req_data0[k*DW +: DW], i_req_data1[k*DW +: DW])});
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        i_req_data0[k*DW +: DW] = a;
        i_req_data1[k*DW +: DW] = b;
    endtask

    // Raise one request, wait (bounded) for its grant, then drop valid after the transfer edge.
    task automatic do_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        set_ops(k, a, b);
        i_req_valid[k] = 1'b1;
        @(negedge clk);
        while (!o_req_ready[k] && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        checks++;
        if (!o_req_ready[k]) begin
            errors++;
            $display("FAIL grant_timeout: req %0d not granted, o_req_ready=%b, required bit set", k, o_req_ready);
        end
        step();
        i_req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        @(negedge clk);
        while ((o_busy || sb_q.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_busy || sb_q.size() != 0) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b pending=%0d, required busy=0 pending=0", o_busy, sb_q.size());
        end
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        i_req_valid = '1;
        i_res_ready = 1'b1;
        i_req_data0 = '0;
        i_req_data1 = '0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({o_res_valid, o_busy, o_req_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b busy=%b ready=%b, required all 0", o_res_valid, o_busy, o_req_ready);
        end
        checks++;
        if ({o_res_id, o_res_relation} !== '0) begin
            errors++;
            $display("FAIL reset_data: id=%0d rel=%h, required 0/0", o_res_id, o_res_relation);
        end
        step();
        i_req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        set_ops(1, 16'd5, 16'd9);
        i_req_valid[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: o_req_ready=%b, required 0010", o_req_ready);
        end
        step();
        i_req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_cmp: busy=%b valid=%b, required 1/0", o_busy, o_res_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (o_res_valid !== 1'b1 || o_res_relation !== 16'h003C || o_res_id !== 2'd1) begin
            errors++;
            $display("FAIL single_result: valid=%b rel=%h id=%0d, required 1/003c/1", o_res_valid, o_res_relation, o_res_id);
        end
        step();
        @(negedge clk);
        checks++;
        if (o_res_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: valid=%b busy=%b, required 0/0", o_res_valid, o_busy);
        end
        step();
    endtask

    task automatic test_relations;
        logic [DW-1:0] ones;
        ones = '1;
        do_req(0, 16'd7, 16'd7);
        wait_idle();
        do_req(0, 16'd9, 16'd5);
        wait_idle();
        do_req(0, 16'd0, ones);
        wait_idle();
        do_req(0, ones, 16'd0);
        wait_idle();
    endtask

    task automatic test_round_robin;
        int ids[$];
        int cyc[$];
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        i_res_ready = 1'b1;
        for (int k = 0; k < NR; k++) set_ops(k, DW'(k * 3), 16'd4);
        i_req_valid = '1;
        for (int c = 0; c < 20 && ids.size() < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < NR; k++) begin
                if (o_req_ready[k]) begin
                    ids.push_back(k);
                    cyc.push_back(c);
                end
            end
            step();
        end
        i_req_valid = '0;
        checks++;
        if (ids.size() != 5) begin
            errors++;
            $display("FAIL rr_count: grants=%0d, required 5", ids.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ids[i] != exp_ids[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: id=%0d, required %0d", i, ids[i], exp_ids[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (cyc[i] - cyc[i-1] != 2) begin
                        errors++;
                        $display("FAIL rr_spacing[%0d]: gap=%0d, required 2", i, cyc[i] - cyc[i-1]);
                    end
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_backpressure;
        i_res_ready = 1'b0;
        do_req(2, 16'd20, 16'd10);
        set_ops(3, 16'd1, 16'd1);
        i_req_valid[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_cmp_ready: o_req_ready=%b, required 0000", o_req_ready);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (o_res_valid !== 1'b1 || o_res_relation !== 16'h003E || o_res_id !== 2'd2 || o_req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b rel=%h id=%0d ready=%b, required 1/003e/2/0000",
                         i, o_res_valid, o_res_relation, o_res_id, o_req_ready);
            end
            step();
        end
        i_res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_regrant: o_req_ready=%b, required 1000", o_req_ready);
        end
        step();
        i_req_valid[3] = 1'b0;
        wait_idle();
    endtask

    task automatic test_operand_change;
        i_res_ready = 1'b1;
        do_req(1, 16'd3, 16'd5);
        set_ops(1, 16'd10, 16'd5);
        wait_idle();
    endtask

    task automatic test_reset_mid;
        i_res_ready = 1'b1;
        do_req(2, 16'd9, 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        set_ops(0, 16'd2, 16'd2);
        set_ops(1, 16'd2, 16'd2);
        set_ops(3, 16'd2, 16'd2);
        i_req_valid = '1;
        @(negedge clk);
        checks++;
        if (o_res_valid !== 1'b0 || o_busy !== 1'b0 || o_res_relation !== '0) begin
            errors++;
            $display("FAIL rstmid_state: valid=%b busy=%b rel=%h, required 0/0/0", o_res_valid, o_busy, o_res_relation);
        end
        checks++;
        if (o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_priority: o_req_ready=%b, required 0001", o_req_ready);
        end
        step();
        i_req_valid = '0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_relations();
        test_round_robin();
        test_backpressure();
        test_operand_change();
        test_reset_mid();
        repeat (4) step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
